// File: rtl/mips_bus_pkg.sv
`default_nettype none
// ============================================================================
// mips_bus_pkg : shared types and constants for the two-master bus arbiter
// Rev 1.0
// ============================================================================
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS_I = 2'd1,
        BUS_D = 2'd2
    } bus_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    localparam logic [3:0] FETCH_BE = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/mips_bus_watchdog.sv
`default_nettype none
// ============================================================================
// mips_bus_watchdog : saturating stall counter with sticky bus error flag
// Rev 1.0
// ============================================================================
module mips_bus_watchdog #(
    parameter int WAIT_LIMIT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic stall,
    input  logic clear,
    input  logic illegal,
    output logic bus_error
);

    localparam int CNT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(WAIT_LIMIT);

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] w_stall_cnt_nxt;
    logic             r_bus_error;

    always_comb begin
        w_stall_cnt_nxt = r_stall_cnt;
        if (clear)
            w_stall_cnt_nxt = '0;
        else if (stall && (r_stall_cnt != C_LIMIT))
            w_stall_cnt_nxt = r_stall_cnt + 1'b1;
    end

    // The flag latches at the edge where the count reaches the limit; the
    // transaction itself is left waiting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
            r_bus_error <= 1'b0;
        end else begin
            r_stall_cnt <= w_stall_cnt_nxt;
            if (illegal || (w_stall_cnt_nxt == C_LIMIT))
                r_bus_error <= 1'b1;
        end
    end

    assign bus_error = r_bus_error;

endmodule
`default_nettype wire

// File: rtl/mips_bus_arbiter.sv
`default_nettype none
// ============================================================================
// mips_bus_arbiter : round-robin Avalon-MM arbiter, fetch port vs data port
// Rev 1.0
// ============================================================================
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int WAIT_LIMIT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] i_address,
    input  logic              i_read,
    output logic              i_waitrequest,
    input  logic [ADDR_W-1:0] d_address,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [3:0]        d_byteenable,
    input  logic [31:0]       d_writedata,
    output logic              d_waitrequest,
    output logic [31:0]       m_readdata,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    output logic [3:0]        byteenable,
    output logic [31:0]       writedata,
    input  logic [31:0]       readdata,
    input  logic              waitrequest,
    output logic              bus_error
);

    bus_state_t r_state, w_state_nxt;
    grant_t     r_last_grant, w_last_grant_nxt;

    logic w_req_i;
    logic w_req_d;
    logic w_done;
    logic w_stall;
    logic w_illegal;

    assign w_req_i = i_read;
    assign w_req_d = d_read | d_write;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_last_grant <= GRANT_D;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_done           = 1'b0;
        w_stall          = 1'b0;
        w_illegal        = 1'b0;
        address          = '0;
        read             = 1'b0;
        write            = 1'b0;
        byteenable       = '0;
        writedata        = '0;

        case (r_state)
            IDLE: begin
                if (w_req_i && w_req_d)
                    w_state_nxt = (r_last_grant == GRANT_D) ? BUS_I : BUS_D;
                else if (w_req_i)
                    w_state_nxt = BUS_I;
                else if (w_req_d)
                    w_state_nxt = BUS_D;
            end

            BUS_I: begin
                address    = i_address;
                read       = i_read;
                byteenable = FETCH_BE;
                if (!w_req_i) begin
                    w_state_nxt = IDLE;
                end else if (!waitrequest) begin
                    w_done           = 1'b1;
                    w_last_grant_nxt = GRANT_I;
                    w_state_nxt      = w_req_d ? BUS_D : BUS_I;
                end else begin
                    w_stall = 1'b1;
                end
            end

            BUS_D: begin
                address    = d_address;
                byteenable = d_byteenable;
                writedata  = d_writedata;
                // A simultaneous read+write is degraded to a read so the slave
                // never sees both strobes.
                read       = d_read;
                write      = d_write & ~d_read;
                w_illegal  = d_read & d_write;
                if (!w_req_d) begin
                    w_state_nxt = IDLE;
                end else if (!waitrequest) begin
                    w_done           = 1'b1;
                    w_last_grant_nxt = GRANT_D;
                    w_state_nxt      = w_req_i ? BUS_I : BUS_D;
                end else begin
                    w_stall = 1'b1;
                end
            end

            default: w_state_nxt = IDLE;
        endcase
    end

    assign i_waitrequest = !((r_state == BUS_I) && !waitrequest);
    assign d_waitrequest = !((r_state == BUS_D) && !waitrequest);
    assign m_readdata    = readdata;

    mips_bus_watchdog #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_watchdog (
        .clk       (clk),
        .reset_n   (reset_n),
        .stall     (w_stall),
        .clear     (w_done || (r_state == IDLE)),
        .illegal   (w_illegal),
        .bus_error (bus_error)
    );

endmodule
`default_nettype wire

// File: tb/tb_mips_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mips_bus_arbiter : directed self-checking bench for mips_bus_arbiter
// Rev 1.0
// ============================================================================
module tb_mips_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] i_address;
    logic        i_read;
    logic        i_waitrequest;
    logic [31:0] d_address;
    logic        d_read;
    logic        d_write;
    logic [3:0]  d_byteenable;
    logic [31:0] d_writedata;
    logic        d_waitrequest;
    logic [31:0] m_readdata;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        bus_error;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mips_bus_arbiter #(
        .ADDR_W     (32),
        .WAIT_LIMIT (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_address     (i_address),
        .i_read        (i_read),
        .i_waitrequest (i_waitrequest),
        .d_address     (d_address),
        .d_read        (d_read),
        .d_write       (d_write),
        .d_byteenable  (d_byteenable),
        .d_writedata   (d_writedata),
        .d_waitrequest (d_waitrequest),
        .m_readdata    (m_readdata),
        .address       (address),
        .read          (read),
        .write         (write),
        .byteenable    (byteenable),
        .writedata     (writedata),
        .readdata      (readdata),
        .waitrequest   (waitrequest),
        .bus_error     (bus_error)
    );

    // Slave model: 256-byte RAM window at 0x1000, a fixed pattern elsewhere.
    logic [7:0] mem [0:255];
    logic [7:0] w_a;
    logic       w_win;
    assign w_a   = address[7:0];
    assign w_win = (address[31:8] == 24'h000010);

    always_comb begin
        readdata = address ^ 32'hA5A5A5A5;
        if (w_win)
            readdata = {mem[w_a + 8'd3], mem[w_a + 8'd2], mem[w_a + 8'd1], mem[w_a]};
    end

    always @(posedge clk) begin
        if (write && !waitrequest && w_win) begin
            if (byteenable[0]) mem[w_a]        <= writedata[7:0];
            if (byteenable[1]) mem[w_a + 8'd1] <= writedata[15:8];
            if (byteenable[2]) mem[w_a + 8'd2] <= writedata[23:16];
            if (byteenable[3]) mem[w_a + 8'd3] <= writedata[31:24];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Move to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_read  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset_n      = 1'b0;
        i_address    = 32'h0;
        i_read       = 1'b1;
        d_address    = 32'h0;
        d_read       = 1'b0;
        d_write      = 1'b0;
        d_byteenable = 4'h0;
        d_writedata  = 32'h0;
        waitrequest  = 1'b1;
        #2;
        check_eq("rst_read",  32'(read),          32'd0);
        check_eq("rst_write", 32'(write),         32'd0);
        check_eq("rst_addr",  address,            32'd0);
        check_eq("rst_be",    32'(byteenable),    32'd0);
        check_eq("rst_wd",    writedata,          32'd0);
        check_eq("rst_iwait", 32'(i_waitrequest), 32'd1);
        check_eq("rst_dwait", 32'(d_waitrequest), 32'd1);
        check_eq("rst_err",   32'(bus_error),     32'd0);
        step();
        reset_n = 1'b1;
        idle_inputs();
        step();

        // Lone fetch with two slave wait cycles
        i_read = 1'b1; i_address = 32'hBFC00000; waitrequest = 1'b1;
        #1;
        check_eq("fetch_c0_read", 32'(read), 32'd0);
        step(); #1;
        check_eq("fetch_c1_read",  32'(read),          32'd1);
        check_eq("fetch_c1_addr",  address,            32'hBFC00000);
        check_eq("fetch_c1_be",    32'(byteenable),    32'hF);
        check_eq("fetch_c1_write", 32'(write),         32'd0);
        check_eq("fetch_c1_iwait", 32'(i_waitrequest), 32'd1);
        step(); #1;
        check_eq("fetch_c2_iwait", 32'(i_waitrequest), 32'd1);
        step();
        waitrequest = 1'b0;
        #1;
        check_eq("fetch_c3_iwait", 32'(i_waitrequest), 32'd0);
        check_eq("fetch_c3_rdata", m_readdata,         32'h1A65A5A5);
        step();
        i_read = 1'b0;
        step(); #1;
        check_eq("fetch_done_idle", 32'(read), 32'd0);

        // Reset while a data read is stalled
        d_read = 1'b1; d_address = 32'h00000020; waitrequest = 1'b1;
        step(); #1;
        check_eq("mid_busd_read", 32'(read), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_read",  32'(read),          32'd0);
        check_eq("mid_rst_dwait", 32'(d_waitrequest), 32'd1);
        step();
        reset_n = 1'b1;
        d_read  = 1'b0;
        #1;
        check_eq("mid_rel_read",  32'(read),          32'd0);
        check_eq("mid_rel_dwait", 32'(d_waitrequest), 32'd1);
        step();

        // Contention after reset: fetch first, write handed off directly
        i_read = 1'b1; i_address = 32'h00000040;
        d_write = 1'b1; d_address = 32'h00001000;
        d_byteenable = 4'b0011; d_writedata = 32'hDEADBEEF;
        waitrequest = 1'b0;
        step(); #1;
        check_eq("cont_c1_addr",  address,            32'h00000040);
        check_eq("cont_c1_read",  32'(read),          32'd1);
        check_eq("cont_c1_iwait", 32'(i_waitrequest), 32'd0);
        step();
        i_read = 1'b0;
        #1;
        check_eq("cont_c2_write", 32'(write),         32'd1);
        check_eq("cont_c2_read",  32'(read),          32'd0);
        check_eq("cont_c2_addr",  address,            32'h00001000);
        check_eq("cont_c2_be",    32'(byteenable),    32'h3);
        check_eq("cont_c2_wd",    writedata,          32'hDEADBEEF);
        check_eq("cont_c2_dwait", 32'(d_waitrequest), 32'd0);
        step();
        d_write = 1'b0;
        step();
        d_read = 1'b1; d_address = 32'h00001000;
        step(); #1;
        check_eq("cont_readback", m_readdata, 32'h0000BEEF);
        step();
        d_read = 1'b0;
        step();

        // Round-robin under continuous contention
        i_read = 1'b1; i_address = 32'h00000100;
        d_read = 1'b1; d_address = 32'h00000200;
        waitrequest = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step(); #1;
            check_eq($sformatf("rr_%0d", k), address,
                     ((k % 2) == 0) ? 32'h00000100 : 32'h00000200);
        end
        idle_inputs();
        step();
        step();

        // Watchdog with WAIT_LIMIT = 4
        d_read = 1'b1; d_address = 32'h00000300; waitrequest = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step(); #1;
            if (k == 4) check_eq("wd_before_limit", 32'(bus_error), 32'd0);
            if (k == 5) check_eq("wd_at_limit",     32'(bus_error), 32'd1);
        end
        check_eq("wd_still_wait", 32'(d_waitrequest), 32'd1);
        step();
        waitrequest = 1'b0;
        #1;
        check_eq("wd_complete", 32'(d_waitrequest), 32'd0);
        check_eq("wd_rdata",    m_readdata,         32'h00000300 ^ 32'hA5A5A5A5);
        step();
        d_read = 1'b0;
        step(); step(); #1;
        check_eq("wd_sticky", 32'(bus_error), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("wd_rst_clear", 32'(bus_error), 32'd0);
        step();
        reset_n = 1'b1;
        step();

        // Illegal simultaneous read and write
        d_read = 1'b1; d_write = 1'b1; d_address = 32'h00002000; waitrequest = 1'b0;
        step(); #1;
        check_eq("ill_read",  32'(read),  32'd1);
        check_eq("ill_write", 32'(write), 32'd0);
        step(); #1;
        check_eq("ill_err", 32'(bus_error), 32'd1);
        idle_inputs();
        step(); step(); #1;
        check_eq("ill_sticky", 32'(bus_error), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
